// File: rtl/pipe_stage_regs_pkg.sv
// pipe_pkg: shared constants and stage-register layouts for pipe_stage_regs.
//   NOP_INSTR   - instruction placed in IF/ID on a bubble (addi x0,x0,0)
//   WB_SEL_LOAD - writeback select encoding for loads
//   if_id_t     - IF/ID register contents
//   id_ex_t     - ID/EX register contents
package pipe_pkg;

   localparam int unsigned PIPE_XLEN   = 32;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam logic [1:0]  WB_SEL_LOAD = 2'b10;

   typedef struct packed {
      logic [PIPE_XLEN-1:0] pc;
      logic [31:0]          instr;
      logic                 valid;
   } if_id_t;

   typedef struct packed {
      logic [PIPE_XLEN-1:0] pc;
      logic [PIPE_XLEN-1:0] rs1_data;
      logic [PIPE_XLEN-1:0] rs2_data;
      logic [PIPE_XLEN-1:0] imm;
      logic [4:0]           rs1_addr;
      logic [4:0]           rs2_addr;
      logic [4:0]           rd_addr;
      logic                 rd_wren;
      logic                 mem_wren;
      logic [1:0]           wb_sel;
      logic                 valid;
   } id_ex_t;

endpackage

// File: rtl/pipe_stage_regs_if.sv
// pipe_stage_regs_if: control, decode-data and stage-output bundle of the
// front-end pipeline registers.
//   master - driver side (hazard unit / decoder / execute), drives i_* signals
//   slave  - the register bank, drives o_* signals
interface pipe_stage_regs_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
);
   // hazard / redirect controls
   logic            i_stall_fetch;
   logic            i_stall_decode;
   logic            i_flush_decode;
   logic            i_flush_execute;
   logic            i_pc_sel;
   logic [XLEN-1:0] i_pc_target;
   // fetch and decode inputs
   logic [31:0]     i_instr;
   logic [4:0]      i_rs1_addr_decode;
   logic [4:0]      i_rs2_addr_decode;
   logic [4:0]      i_rd_addr_decode;
   logic            i_rd_wren_decode;
   logic            i_mem_wren_decode;
   logic [1:0]      i_wb_sel_decode;
   logic [XLEN-1:0] i_rs1_data_decode;
   logic [XLEN-1:0] i_rs2_data_decode;
   logic [XLEN-1:0] i_imm_decode;
   // stage outputs
   logic [XLEN-1:0] o_pc;
   logic [XLEN-1:0] o_pc_decode;
   logic [31:0]     o_instr_decode;
   logic            o_valid_decode;
   logic [XLEN-1:0] o_pc_execute;
   logic [XLEN-1:0] o_rs1_data_execute;
   logic [XLEN-1:0] o_rs2_data_execute;
   logic [XLEN-1:0] o_imm_execute;
   logic [4:0]      o_rs1_addr_execute;
   logic [4:0]      o_rs2_addr_execute;
   logic [4:0]      o_rd_addr_execute;
   logic            o_rd_wren_execute;
   logic            o_mem_wren_execute;
   logic [1:0]      o_wb_sel_execute;
   logic            o_valid_execute;
   logic [CNT_W-1:0] o_stall_cnt;
   logic [CNT_W-1:0] o_flush_cnt;

   modport master (
      output i_stall_fetch, i_stall_decode, i_flush_decode, i_flush_execute,
             i_pc_sel, i_pc_target, i_instr,
             i_rs1_addr_decode, i_rs2_addr_decode, i_rd_addr_decode,
             i_rd_wren_decode, i_mem_wren_decode, i_wb_sel_decode,
             i_rs1_data_decode, i_rs2_data_decode, i_imm_decode,
      input  o_pc, o_pc_decode, o_instr_decode, o_valid_decode,
             o_pc_execute, o_rs1_data_execute, o_rs2_data_execute, o_imm_execute,
             o_rs1_addr_execute, o_rs2_addr_execute, o_rd_addr_execute,
             o_rd_wren_execute, o_mem_wren_execute, o_wb_sel_execute,
             o_valid_execute, o_stall_cnt, o_flush_cnt
   );

   modport slave (
      input  i_stall_fetch, i_stall_decode, i_flush_decode, i_flush_execute,
             i_pc_sel, i_pc_target, i_instr,
             i_rs1_addr_decode, i_rs2_addr_decode, i_rd_addr_decode,
             i_rd_wren_decode, i_mem_wren_decode, i_wb_sel_decode,
             i_rs1_data_decode, i_rs2_data_decode, i_imm_decode,
      output o_pc, o_pc_decode, o_instr_decode, o_valid_decode,
             o_pc_execute, o_rs1_data_execute, o_rs2_data_execute, o_imm_execute,
             o_rs1_addr_execute, o_rs2_addr_execute, o_rd_addr_execute,
             o_rd_wren_execute, o_mem_wren_execute, o_wb_sel_execute,
             o_valid_execute, o_stall_cnt, o_flush_cnt
   );

endinterface

// File: rtl/pipe_stage_regs_pipe_reg.sv
// pipe_reg: generic pipeline register with hold and bubble insertion.
//   clk, rst_n - clock, asynchronous active-low reset (loads RESET_VAL)
//   stall      - hold current contents
//   flush      - load BUBBLE_VAL; has priority over stall
//   d, q       - next-stage data in, registered data out
module pipe_reg #(
   parameter int unsigned      WIDTH      = 1,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_VAL;
      end else if (flush) begin
         q <= BUBBLE_VAL;
      end else if (!stall) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: front-end register bank (PC, IF/ID, ID/EX) applying hazard
// stall/flush controls and execute redirects, plus saturating stall/flush
// event counters.
//   i_clk   - clock, rising edge
//   i_reset - asynchronous reset, active-low
//   bus     - pipe_stage_regs_if.slave: controls, decode inputs, stage outputs
module pipe_stage_regs
   import pipe_pkg::PIPE_XLEN;
   import pipe_pkg::if_id_t;
   import pipe_pkg::id_ex_t;
#(
   parameter int unsigned     XLEN      = PIPE_XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = pipe_pkg::NOP_INSTR,
   parameter int unsigned     CNT_W     = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   pipe_stage_regs_if.slave  bus
);

   localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

   logic [XLEN-1:0]  pc_d, pc_q;
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
   if_id_t           if_id_d, if_id_q;
   id_ex_t           id_ex_d, id_ex_q;

   // PC: redirect beats stall
   always_comb begin
      pc_d = pc_q + XLEN'(4);
      if (bus.i_pc_sel) begin
         pc_d = bus.i_pc_target;
      end else if (bus.i_stall_fetch) begin
         pc_d = pc_q;
      end
   end

   // A stall that coincides with a redirect is not counted as a stall.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (bus.i_stall_fetch && !bus.i_pc_sel && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (bus.i_pc_sel && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         pc_q        <= RESET_PC;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      if_id_d = '{pc: pc_q, instr: bus.i_instr, valid: 1'b1};
   end

   pipe_reg #(
      .WIDTH     ($bits(if_id_t)),
      .RESET_VAL (IF_ID_BUBBLE),
      .BUBBLE_VAL(IF_ID_BUBBLE)
   ) u_if_id (
      .clk  (i_clk),
      .rst_n(i_reset),
      .stall(bus.i_stall_decode),
      .flush(bus.i_flush_decode),
      .d    (if_id_d),
      .q    (if_id_q)
   );

   always_comb begin
      id_ex_d = '{
         pc:       if_id_q.pc,
         rs1_data: bus.i_rs1_data_decode,
         rs2_data: bus.i_rs2_data_decode,
         imm:      bus.i_imm_decode,
         rs1_addr: bus.i_rs1_addr_decode,
         rs2_addr: bus.i_rs2_addr_decode,
         rd_addr:  bus.i_rd_addr_decode,
         rd_wren:  bus.i_rd_wren_decode,
         mem_wren: bus.i_mem_wren_decode,
         wb_sel:   bus.i_wb_sel_decode,
         valid:    if_id_q.valid
      };
   end

   // No stall on ID/EX: a held decode stage is covered by flushing execute.
   pipe_reg #(
      .WIDTH     ($bits(id_ex_t)),
      .RESET_VAL ('0),
      .BUBBLE_VAL('0)
   ) u_id_ex (
      .clk  (i_clk),
      .rst_n(i_reset),
      .stall(1'b0),
      .flush(bus.i_flush_execute),
      .d    (id_ex_d),
      .q    (id_ex_q)
   );

   assign bus.o_pc               = pc_q;
   assign bus.o_pc_decode        = if_id_q.pc;
   assign bus.o_instr_decode     = if_id_q.instr;
   assign bus.o_valid_decode     = if_id_q.valid;
   assign bus.o_pc_execute       = id_ex_q.pc;
   assign bus.o_rs1_data_execute = id_ex_q.rs1_data;
   assign bus.o_rs2_data_execute = id_ex_q.rs2_data;
   assign bus.o_imm_execute      = id_ex_q.imm;
   assign bus.o_rs1_addr_execute = id_ex_q.rs1_addr;
   assign bus.o_rs2_addr_execute = id_ex_q.rs2_addr;
   assign bus.o_rd_addr_execute  = id_ex_q.rd_addr;
   assign bus.o_rd_wren_execute  = id_ex_q.rd_wren;
   assign bus.o_mem_wren_execute = id_ex_q.mem_wren;
   assign bus.o_wb_sel_execute   = id_ex_q.wb_sel;
   assign bus.o_valid_execute    = id_ex_q.valid;
   assign bus.o_stall_cnt        = stall_cnt_q;
   assign bus.o_flush_cnt        = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb_pipe_stage_regs: directed bench for pipe_stage_regs with a behavioural
// model checked every falling edge plus hand-computed literal checks.
module tb_pipe_stage_regs;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          CMAX = 15;   // counters built 4 bits wide

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_stage_regs_if #(.XLEN(32), .CNT_W(4)) bus ();

   pipe_stage_regs #(.XLEN(32), .CNT_W(4)) u_dut (
      .i_clk  (clk),
      .i_reset(rst_n),
      .bus    (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: what each stage must hold, derived from the stage rules.
   logic [31:0] m_pc, m_d_pc, m_d_instr;
   logic        m_d_valid;
   logic [31:0] m_e_pc, m_e_rs1, m_e_rs2, m_e_imm;
   logic [4:0]  m_e_a1, m_e_a2, m_e_rd;
   logic        m_e_rdw, m_e_mw, m_e_valid;
   logic [1:0]  m_e_wb;
   int          m_scnt, m_fcnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= 32'h0; m_d_pc <= 32'h0; m_d_instr <= NOP; m_d_valid <= 1'b0;
         m_e_pc <= 0; m_e_rs1 <= 0; m_e_rs2 <= 0; m_e_imm <= 0;
         m_e_a1 <= 0; m_e_a2 <= 0; m_e_rd <= 0;
         m_e_rdw <= 0; m_e_mw <= 0; m_e_wb <= 0; m_e_valid <= 0;
         m_scnt <= 0; m_fcnt <= 0;
      end else begin
         if (bus.i_pc_sel) m_pc <= bus.i_pc_target;
         else if (!bus.i_stall_fetch) m_pc <= m_pc + 32'd4;
         if (bus.i_flush_decode) begin
            m_d_pc <= 32'h0; m_d_instr <= NOP; m_d_valid <= 1'b0;
         end else if (!bus.i_stall_decode) begin
            m_d_pc <= m_pc; m_d_instr <= bus.i_instr; m_d_valid <= 1'b1;
         end
         if (bus.i_flush_execute) begin
            m_e_pc <= 0; m_e_rs1 <= 0; m_e_rs2 <= 0; m_e_imm <= 0;
            m_e_a1 <= 0; m_e_a2 <= 0; m_e_rd <= 0;
            m_e_rdw <= 0; m_e_mw <= 0; m_e_wb <= 0; m_e_valid <= 0;
         end else begin
            m_e_pc <= m_d_pc; m_e_valid <= m_d_valid;
            m_e_rs1 <= bus.i_rs1_data_decode; m_e_rs2 <= bus.i_rs2_data_decode;
            m_e_imm <= bus.i_imm_decode;
            m_e_a1 <= bus.i_rs1_addr_decode; m_e_a2 <= bus.i_rs2_addr_decode;
            m_e_rd <= bus.i_rd_addr_decode;
            m_e_rdw <= bus.i_rd_wren_decode; m_e_mw <= bus.i_mem_wren_decode;
            m_e_wb <= bus.i_wb_sel_decode;
         end
         if (bus.i_stall_fetch && !bus.i_pc_sel) m_scnt <= (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
         if (bus.i_pc_sel) m_fcnt <= (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("pc",        bus.o_pc,               m_pc);
         check("pc_dec",    bus.o_pc_decode,        m_d_pc);
         check("instr_dec", bus.o_instr_decode,     m_d_instr);
         check("valid_dec", bus.o_valid_decode,     m_d_valid);
         check("pc_ex",     bus.o_pc_execute,       m_e_pc);
         check("rs1d_ex",   bus.o_rs1_data_execute, m_e_rs1);
         check("rs2d_ex",   bus.o_rs2_data_execute, m_e_rs2);
         check("imm_ex",    bus.o_imm_execute,      m_e_imm);
         check("rs1a_ex",   bus.o_rs1_addr_execute, m_e_a1);
         check("rs2a_ex",   bus.o_rs2_addr_execute, m_e_a2);
         check("rd_ex",     bus.o_rd_addr_execute,  m_e_rd);
         check("rdw_ex",    bus.o_rd_wren_execute,  m_e_rdw);
         check("mw_ex",     bus.o_mem_wren_execute, m_e_mw);
         check("wb_ex",     bus.o_wb_sel_execute,   m_e_wb);
         check("valid_ex",  bus.o_valid_execute,    m_e_valid);
         check("stall_cnt", bus.o_stall_cnt,        m_scnt);
         check("flush_cnt", bus.o_flush_cnt,        m_fcnt);
      end
   end

   int k = 0;

   // Apply one cycle of controls with fresh decode data, then sample #1 after the edge.
   task automatic step(input bit sf, input bit sd, input bit fd, input bit fe,
                       input bit ps, input logic [31:0] tgt);
      logic [31:0] kk;
      kk = 32'(k);
      bus.i_stall_fetch     = sf;
      bus.i_stall_decode    = sd;
      bus.i_flush_decode    = fd;
      bus.i_flush_execute   = fe;
      bus.i_pc_sel          = ps;
      bus.i_pc_target       = tgt;
      bus.i_instr           = (k < 4) ? NOP : (NOP | (kk << 12));
      bus.i_rs1_addr_decode = kk[4:0];
      bus.i_rs2_addr_decode = kk[4:0] + 5'd1;
      bus.i_rd_addr_decode  = kk[4:0] + 5'd2;
      bus.i_rd_wren_decode  = 1'b1;
      bus.i_mem_wren_decode = kk[0];
      bus.i_wb_sel_decode   = kk[1:0];
      bus.i_rs1_data_decode = 32'hA000_0000 + kk;
      bus.i_rs2_data_decode = 32'hB000_0000 ^ kk;
      bus.i_imm_decode      = kk << 2;
      k++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.i_stall_fetch = 0; bus.i_stall_decode = 0; bus.i_flush_decode = 0;
      bus.i_flush_execute = 0; bus.i_pc_sel = 0; bus.i_pc_target = 0; bus.i_instr = NOP;
      bus.i_rs1_addr_decode = 0; bus.i_rs2_addr_decode = 0; bus.i_rd_addr_decode = 0;
      bus.i_rd_wren_decode = 0; bus.i_mem_wren_decode = 0; bus.i_wb_sel_decode = 0;
      bus.i_rs1_data_decode = 0; bus.i_rs2_data_decode = 0; bus.i_imm_decode = 0;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc",    bus.o_pc, 32'h0);
      check("rst_instr", bus.o_instr_decode, NOP);
      check("rst_vd",    bus.o_valid_decode, 1'b0);
      check("rst_ve",    bus.o_valid_execute, 1'b0);
      rst_n = 1'b1;

      // Free run from reset
      step(0, 0, 0, 0, 0, 0);
      check("run1_pc", bus.o_pc, 32'h4);
      check("run1_vd", bus.o_valid_decode, 1'b1);
      check("run1_ve", bus.o_valid_execute, 1'b0);
      step(0, 0, 0, 0, 0, 0);
      check("run2_pc", bus.o_pc, 32'h8);
      check("run2_ve", bus.o_valid_execute, 1'b1);
      step(0, 0, 0, 0, 0, 0);
      check("run3_pc", bus.o_pc, 32'hC);
      check("run3_pcex", bus.o_pc_execute, 32'h4);
      step(0, 0, 0, 0, 0, 0);
      check("run4_pc", bus.o_pc, 32'h10);
      check("run4_rdw", bus.o_rd_wren_execute, 1'b1);

      // Load-use at o_pc = 0x10
      step(1, 1, 0, 1, 0, 0);
      check("lu_pc",   bus.o_pc, 32'h10);
      check("lu_pcd",  bus.o_pc_decode, 32'hC);
      check("lu_ve",   bus.o_valid_execute, 1'b0);
      check("lu_rdw",  bus.o_rd_wren_execute, 1'b0);
      check("lu_scnt", bus.o_stall_cnt, 4'd1);
      step(0, 0, 0, 0, 0, 0);
      check("lu2_pc",   bus.o_pc, 32'h14);
      check("lu2_pcex", bus.o_pc_execute, 32'hC);

      // Redirect to 0x200
      step(0, 0, 1, 1, 1, 32'h200);
      check("rd_pc",    bus.o_pc, 32'h200);
      check("rd_vd",    bus.o_valid_decode, 1'b0);
      check("rd_instr", bus.o_instr_decode, NOP);
      check("rd_ve",    bus.o_valid_execute, 1'b0);
      check("rd_fcnt",  bus.o_flush_cnt, 4'd1);
      step(0, 0, 0, 0, 0, 0);
      check("rd2_pc",  bus.o_pc, 32'h204);
      check("rd2_pcd", bus.o_pc_decode, 32'h200);
      check("rd2_ve",  bus.o_valid_execute, 1'b0);

      // Redirect together with stall
      step(1, 0, 0, 0, 1, 32'h80);
      check("rs_pc",   bus.o_pc, 32'h80);
      check("rs_scnt", bus.o_stall_cnt, 4'd1);
      check("rs_fcnt", bus.o_flush_cnt, 4'd2);

      // PC wrap
      step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      check("wrap_pc0", bus.o_pc, 32'hFFFF_FFFC);
      step(0, 0, 0, 0, 0, 0);
      check("wrap_pc1", bus.o_pc, 32'h0);

      // Flush beats stall in IF/ID
      step(0, 1, 1, 0, 0, 0);
      check("fs_vd", bus.o_valid_decode, 1'b0);

      // Stall counter saturation
      for (int i = 0; i < 16; i++) step(1, 1, 0, 1, 0, 0);
      check("sat_scnt", bus.o_stall_cnt, 4'd15);
      check("sat_pc",   bus.o_pc, 32'h4);
      step(0, 0, 0, 0, 0, 0);

      // Asynchronous reset pulse between edges during a stall
      step(1, 1, 0, 1, 0, 0);
      #1 rst_n = 1'b0;
      #1;
      check("ar_pc",    bus.o_pc, 32'h0);
      check("ar_instr", bus.o_instr_decode, NOP);
      check("ar_vd",    bus.o_valid_decode, 1'b0);
      check("ar_scnt",  bus.o_stall_cnt, 4'd0);
      check("ar_fcnt",  bus.o_flush_cnt, 4'd0);
      #3 rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      check("ar2_pc", bus.o_pc, 32'h4);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
